// File: rtl/bus_mem_responder.sv
// Memory responder at the far end of the L1 coherence bus: serves line reads and
// write-backs from a word array, with the line size taken per request from active_offset.
module bus_mem_responder #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned MSG_BITS        = 4,
  parameter int unsigned BUS_OFFSET_BITS = 0,
  parameter int unsigned MAX_OFFSET_BITS = 3,
  parameter int unsigned MEM_INDEX_BITS  = 10,
  parameter int unsigned MEM_LATENCY     = 2
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [MSG_BITS-1:0]                             bus_msg_in,
  input  logic [ADDRESS_BITS-1:0]                         bus_address_in,
  input  logic [((1 << BUS_OFFSET_BITS) * DATA_WIDTH)-1:0] bus_data_in,
  input  logic [$clog2(MAX_OFFSET_BITS):0]                active_offset,
  output logic [MSG_BITS-1:0]                             bus_msg_out,
  output logic [ADDRESS_BITS-1:0]                         bus_address_out,
  output logic [((1 << BUS_OFFSET_BITS) * DATA_WIDTH)-1:0] bus_data_out,
  output logic                                            req_ready
);

  localparam int unsigned BUS_WORDS = 1 << BUS_OFFSET_BITS;
  localparam int unsigned BEAT_DW   = BUS_WORDS * DATA_WIDTH;
  localparam int unsigned DEPTH     = 1 << MEM_INDEX_BITS;
  localparam int unsigned OFF_W     = $clog2(MAX_OFFSET_BITS) + 1;
  localparam int unsigned BEAT_W    = (MAX_OFFSET_BITS > BUS_OFFSET_BITS) ?
                                      (MAX_OFFSET_BITS - BUS_OFFSET_BITS) : 1;
  localparam int unsigned LAT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [MSG_BITS-1:0] NO_REQ    = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] R_REQ     = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] WB_REQ    = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] MEM_RESP  = MSG_BITS'(5);
  localparam logic [MSG_BITS-1:0] MEM_READY = MSG_BITS'(6);
  localparam logic [MSG_BITS-1:0] MEM_DONE  = MSG_BITS'(7);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [LAT_W-1:0]          cnt_q, cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [BEAT_W-1:0]         last_q, last_d;
  logic [ADDRESS_BITS-1:0]   base_q, base_d;
  logic                      op_wr_q, op_wr_d;
  logic [MSG_BITS-1:0]       msg_q, msg_d;
  logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
  logic [BEAT_DW-1:0]        data_q, data_d;
  logic                      ready_q, ready_d;

  logic [OFF_W-1:0]          off_c;
  logic [ADDRESS_BITS-1:0]   base_c;
  logic [BEAT_W-1:0]         last_c;
  logic [ADDRESS_BITS-1:0]   next_addr_c;
  logic [ADDRESS_BITS-1:0]   rd_addr_c;
  logic [BEAT_DW-1:0]        rd_data_c;
  logic                      go_c;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

  // Line geometry of the incoming request, offset clamped to the largest supported line
  always_comb begin
    off_c  = (active_offset > OFF_W'(MAX_OFFSET_BITS)) ? OFF_W'(MAX_OFFSET_BITS) : active_offset;
    base_c = bus_address_in & ~((ADDRESS_BITS'(1) << off_c) - ADDRESS_BITS'(1));
    last_c = '0;
    if (off_c > OFF_W'(BUS_OFFSET_BITS))
      last_c = BEAT_W'((32'(1) << (off_c - OFF_W'(BUS_OFFSET_BITS))) - 32'(1));
  end

  assign next_addr_c = addr_q + ADDRESS_BITS'(BUS_WORDS);

  // Address of the beat that will be presented after the coming edge
  always_comb begin
    rd_addr_c = base_q;
    if (state_q == ST_IDLE)      rd_addr_c = base_c;
    else if (state_q == ST_READ) rd_addr_c = next_addr_c;
  end

  always_comb begin
    rd_data_c = '0;
    for (int j = 0; j < int'(BUS_WORDS); j++)
      rd_data_c[j*DATA_WIDTH +: DATA_WIDTH] =
        mem_q[MEM_INDEX_BITS'(rd_addr_c + ADDRESS_BITS'(j))];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    last_d  = last_q;
    base_d  = base_q;
    op_wr_d = op_wr_q;
    msg_d   = msg_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = ready_q;
    go_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        msg_d   = NO_REQ;
        ready_d = 1'b1;
        if (ready_q && (bus_msg_in == R_REQ || bus_msg_in == WB_REQ)) begin
          op_wr_d = (bus_msg_in == WB_REQ);
          base_d  = base_c;
          last_d  = last_c;
          cnt_d   = '0;
          ready_d = 1'b0;
          if (MEM_LATENCY == 0) go_c = 1'b1;
          else                  state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_W'(MEM_LATENCY - 1)) go_c = 1'b1;
        else                                  cnt_d = cnt_q + LAT_W'(1);
      end
      ST_READ, ST_WRITE: begin
        if (beat_q == last_q) begin
          state_d = ST_DONE;
          msg_d   = MEM_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
          addr_d = next_addr_c;
          if (state_q == ST_READ) data_d = rd_data_c;
        end
      end
      ST_DONE: begin
        if (bus_msg_in == NO_REQ) begin
          state_d = ST_IDLE;
          msg_d   = NO_REQ;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // First beat of the data phase
    if (go_c) begin
      state_d = op_wr_d ? ST_WRITE : ST_READ;
      beat_d  = '0;
      addr_d  = base_d;
      msg_d   = op_wr_d ? MEM_READY : MEM_RESP;
      if (!op_wr_d) data_d = rd_data_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      base_q  <= '0;
      op_wr_q <= 1'b0;
      msg_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      base_q  <= base_d;
      op_wr_q <= op_wr_d;
      msg_q   <= msg_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  // Write-back beat lands at the close of its MEM_READY cycle; contents survive reset
  always_ff @(posedge clock) begin
    if (!reset && state_q == ST_WRITE) begin
      for (int j = 0; j < int'(BUS_WORDS); j++)
        mem_q[MEM_INDEX_BITS'(addr_q + ADDRESS_BITS'(j))] <= bus_data_in[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus_msg_out     = msg_q;
  assign bus_address_out = addr_q;
  assign bus_data_out    = data_q;
  assign req_ready       = ready_q;

endmodule
